// File: rtl/matrix_burst_fetch.sv
// Burst-mode Avalon-MM read DMA that streams an N x N matrix into the determinant RAM.
// Optional build macro MATRIX_FETCH_PERF_EN adds the perf_cycles busy-cycle counter.
module matrix_burst_fetch #(
    parameter int BURST_LEN  = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_ptr,
    input  logic [5:0]  mxsize,
    output logic [29:0] address,
    output logic        read,
    output logic [2:0]  burstcount,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic        readdatavalid,
    output logic [9:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        wr_en,
    output logic        busy,
    output logic        done
`ifdef MATRIX_FETCH_PERF_EN
    ,
    output logic [15:0] perf_cycles
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;
    state_t state;

    logic [29:0]   cur_ptr;
    logic [5:0]    n_lat;
    logic [10:0]   req_rem, ret_rem;
    logic [CW-1:0] outstanding, fifo_count;
    logic [AW-1:0] wptr, rptr;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [4:0]    row, col;

    logic          accept, push, pop, start_ok, qualify;
    logic [2:0]    acc_bc, bc_nxt;
    logic [10:0]   req_rem_nxt, total;
    logic [29:0]   cur_ptr_nxt;
    logic [CW-1:0] out_nxt, cnt_nxt;
    logic [CW:0]   free_nxt;
    logic          unused_hi;

    assign unused_hi = ^base_ptr[31:30];

    // Next-cycle view of the credit state: this cycle's accepted burst, push and pop
    // are all folded in before deciding whether the following burst fits.
    always_comb begin
        accept      = read && !waitrequest;
        push        = readdatavalid;
        pop         = (fifo_count != '0);
        acc_bc      = accept ? burstcount : 3'd0;
        req_rem_nxt = req_rem - 11'(acc_bc);
        cur_ptr_nxt = cur_ptr + {25'd0, acc_bc, 2'b00};
        out_nxt     = outstanding + CW'(acc_bc) - CW'(push);
        cnt_nxt     = fifo_count + CW'(push) - CW'(pop);
        bc_nxt      = (req_rem_nxt >= 11'(BURST_LEN)) ? 3'(BURST_LEN) : req_rem_nxt[2:0];
        free_nxt    = (CW+1)'(FIFO_DEPTH) - {1'b0, cnt_nxt} - {1'b0, out_nxt};
        qualify     = (req_rem_nxt != '0) && (free_nxt >= (CW+1)'(bc_nxt));
        start_ok    = (mxsize != '0) && (mxsize <= 6'd32);
        total       = 11'(mxsize) * 11'(mxsize);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cur_ptr     <= '0;
            n_lat       <= '0;
            req_rem     <= '0;
            ret_rem     <= '0;
            outstanding <= '0;
            address     <= '0;
            read        <= 1'b0;
            burstcount  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done        <= 1'b0;
            outstanding <= out_nxt;
            if (push)
                ret_rem <= ret_rem - 11'd1;
            case (state)
                IDLE: if (start) begin
                    if (start_ok) begin
                        cur_ptr <= base_ptr[29:0];
                        n_lat   <= mxsize;
                        req_rem <= total;
                        ret_rem <= total;
                        busy    <= 1'b1;
                        state   <= REQ;
                    end else begin
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                REQ: begin
                    cur_ptr <= cur_ptr_nxt;
                    req_rem <= req_rem_nxt;
                    if (!(read && waitrequest)) begin
                        if (qualify) begin
                            read       <= 1'b1;
                            address    <= cur_ptr_nxt;
                            burstcount <= bc_nxt;
                        end else begin
                            read <= 1'b0;
                            if (req_rem_nxt == '0)
                                state <= DRAIN;
                        end
                    end
                end
                DRAIN: if (ret_rem == '0 && fifo_count == '0) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= readdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            row        <= '0;
            col        <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_en      <= 1'b0;
        end else begin
            fifo_count <= cnt_nxt;
            wr_en      <= pop;
            if (push)
                wptr <= wptr + AW'(1);
            if (pop) begin
                rptr    <= rptr + AW'(1);
                wr_data <= mem[rptr];
                wr_addr <= {row, col};
                if ({1'b0, col} == n_lat - 6'd1) begin
                    col <= '0;
                    row <= row + 5'd1;
                end else begin
                    col <= col + 5'd1;
                end
            end
            if (state == IDLE && start) begin
                row <= '0;
                col <= '0;
            end
        end
    end

`ifdef MATRIX_FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            perf_cycles <= '0;
        else if (state == IDLE && start)
            perf_cycles <= '0;
        else if (busy && perf_cycles != 16'hFFFF)
            perf_cycles <= perf_cycles + 16'd1;
    end
`endif

endmodule
